// File: rtl/serial_adder.sv
// serial_adder: bit-serial word adder, one full-adder cell plus a carry flop.
// Operands are taken on an in_valid/in_ready handshake and summed LSB first,
// one bit per clock; the result is offered on an out_valid/out_ready handshake.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting A-B.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // count must reach WIDTH-1; a 1-bit word still needs a 1-bit counter
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nx;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic [CW-1:0]    count;
    logic             last;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // operand preparation: subtraction is A + ~B + 1, CIN ignored
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign last = (count == CW'(WIDTH - 1));

    // the single full-adder cell and the right-shifted sum word it feeds
    always_comb begin
        fa_s   = a_sr[0] ^ b_sr[0] ^ carry;
        fa_c   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        sum_nx = sum_sr >> 1;
        sum_nx[WIDTH-1] = fa_s;
    end

    // state register; reset may land mid-word and simply abandons it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and handshake outputs, decoded from state only
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ADD;
            end
            ADD: begin
                if (last) state_nx = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // datapath: operand capture, per-bit shift, result load on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a;
                        b_sr   <= b_load;
                        carry  <= carry_load;
                        sum_sr <= '0;
                        count  <= '0;
                    end
                end
                ADD: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_nx;
                    carry  <= fa_c;
                    count  <= count + CW'(1);
                    if (last) begin
                        sum_q  <= sum_nx;
                        cout_q <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table plus hand-written multi-cycle
// sequences (mid-word reset, backpressure, back-to-back streaming).
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
    );

    always #5 clk = ~clk;

    // global watchdog so a stuck design still ends the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, want completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
        end
    endtask

    // one full transaction with the result consumed immediately
    task automatic xfer(input vec_t v, input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        check({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check({nm, "_latency"}, n, W);
        check({nm, "_sum"},  {24'd0, sum}, {24'd0, v.es});
        check({nm, "_cout"}, {31'd0, cout}, {31'd0, v.ec});
        check({nm, "_excl"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, "_drop"}, {30'd0, out_valid, in_ready}, 32'd1);
        check({nm, "_keep"}, {23'd0, cout, sum}, {23'd0, v.ec, v.es});
    endtask

    vec_t tbl[6];
    vec_t sv[3];
    logic [W-1:0] ra[5], rb[5];
    logic         rc[5];
    logic [W:0]   model;
    int           acc_prev, n;

    initial begin
        tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[5] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0};
        sv[0]  = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1};
        sv[1]  = '{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0};
        sv[2]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};

        in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0; sub = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        check("reset_state", {23'd0, in_ready, out_valid, cout, sum}, {23'd0, 1'b1, 1'b0, 1'b0, 8'h00});

        // directed table
        for (int i = 0; i < 6; i++) xfer(tbl[i], $sformatf("vec%0d", i));

        // mid-word reset: result 0xFF left in SUM, then abort a new word
        a = 8'h12; b = 8'h34; cin = 0; in_valid = 1;
        tick();
        in_valid = 0;
        tick(); tick();
        rst_n = 0;
        #1;
        check("async_reset", {23'd0, in_ready, out_valid, cout, sum}, {23'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        tick();
        rst_n = 1;
        tick();
        xfer('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0}, "post_reset");

        // backpressure: result 0x4C held while new operands wait
        a = 8'h3C; b = 8'h0F; cin = 1; in_valid = 1;
        tick();
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("bp_sum0", {24'd0, sum}, 32'h4C);
        a = 8'h55; b = 8'h11; cin = 0; in_valid = 1; out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i), {22'd0, out_valid, in_ready, sum}, {22'd0, 1'b1, 1'b0, 8'h4C});
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        check("bp_idle", {30'd0, in_ready, out_valid}, 32'd2);
        tick();
        in_valid = 0;
        check("bp_accept", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("bp_new_sum", {23'd0, cout, sum}, {23'd0, 1'b0, 8'h66});
        out_ready = 1; tick(); out_ready = 0;

        // back-to-back stream with out_ready tied high
        for (int i = 0; i < 4; i++) begin
            ra[i] = W'($urandom); rb[i] = W'($urandom); rc[i] = 1'($urandom);
        end
        out_ready = 1;
        a = ra[0]; b = rb[0]; cin = rc[0]; in_valid = 1;
        tick();
        acc_prev = cyc;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin a = ra[i+1]; b = rb[i+1]; cin = rc[i+1]; end
            else in_valid = 0;
            n = 0;
            while (!out_valid && n < 50) begin tick(); n++; end
            model = {1'b0, ra[i]} + {1'b0, rb[i]} + {{W{1'b0}}, rc[i]};
            check($sformatf("b2b%0d_res", i), {23'd0, cout, sum}, {23'd0, model});
            tick();
            if (i < 3) begin
                tick();
                check($sformatf("b2b%0d_gap", i), cyc - acc_prev, W + 2);
                acc_prev = cyc;
            end
        end
        out_ready = 0;
        tick();
        check("b2b_done", {30'd0, in_ready, out_valid}, 32'd2);

`ifdef SERIAL_ADDER_SUB_EN
        for (int i = 0; i < 3; i++) xfer(sv[i], $sformatf("sub%0d", i));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
